// File: rtl/tdm_pkg.sv
// Shared types and helpers for the tdm_mux serializer.
// Default slice geometry matches tdm_mux's default WIDTH_IN/WIDTH_OUT.
package tdm_pkg;

    localparam int unsigned WidthInDef  = 16;
    localparam int unsigned WidthOutDef = 4;
    localparam int unsigned RatioDef    = WidthInDef / WidthOutDef;

    typedef enum logic {IDLE, SEND} state_e;

    typedef logic [$clog2(RatioDef)-1:0] slice_idx_t;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tdm_slice_sel.sv
// Find-first-set over the remaining slice mask; is_last flags that no higher bit is set.
module tdm_slice_sel #(
    parameter int unsigned RATIO = 4,
    localparam int unsigned IdxW = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic [RATIO-1:0] mask_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             found_o,
    output logic             last_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o   = IdxW'(i);
                found_o = 1'b1;
            end
        end
        // The selected bit lands at position 0; anything above it means more slices follow.
        last_o = found_o && ((mask_i >> idx_o) == RATIO'(1));
    end

endmodule

// File: rtl/tdm_mux.sv
// Wide-to-narrow serializer: one WIDTH_IN word in, RATIO WIDTH_OUT slices out, LSB slice first.
// Define TDM_MUX_SKIP_EN to honour i_slice_valid_in and skip unoccupied slices.
module tdm_mux
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH_IN  = WidthInDef,
    parameter int unsigned WIDTH_OUT = WidthOutDef,
    localparam int unsigned RATIO    = WIDTH_IN / WIDTH_OUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH_IN-1:0]  i_data_in,
    input  logic [RATIO-1:0]     i_slice_valid_in,
    input  logic                 i_valid_in,
    output logic                 o_ready_out,
    output logic [WIDTH_OUT-1:0] o_data_out,
    output logic                 o_valid_out,
    output logic                 o_last_out,
    input  logic                 i_ready_in,
    output logic                 o_busy
);

    localparam int unsigned IdxW = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (RATIO < 2 || (WIDTH_IN % WIDTH_OUT) != 0) begin : g_bad_cfg
        $error("tdm_mux: WIDTH_IN must be a multiple of WIDTH_OUT with ratio >= 2");
    end

    state_e               state_q, state_d;
    logic [WIDTH_IN-1:0]  data_q, data_d;
    logic [WIDTH_OUT-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    logic                 in_xfer, out_xfer, advance;
    logic [WIDTH_IN-1:0]  word;
    logic [IdxW-1:0]      sel_idx;
    logic                 sel_found, sel_last;
    logic [RATIO-1:0]     eff_mask;

    // Combinational from i_ready_in so a new word loads in the same cycle the last slice leaves.
    assign o_ready_out = (state_q == IDLE) || (valid_q && last_q && i_ready_in);
    assign in_xfer     = i_valid_in && o_ready_out;
    assign out_xfer    = valid_q && i_ready_in;
    assign advance     = out_xfer && !last_q;
    assign word        = in_xfer ? i_data_in : data_q;

`ifdef TDM_MUX_SKIP_EN
    logic [RATIO-1:0] mask_q, mask_d, sel_mask;

    assign eff_mask = i_slice_valid_in;
    assign sel_mask = in_xfer ? eff_mask : mask_q;

    tdm_slice_sel #(.RATIO(RATIO)) u_slice_sel (
        .mask_i  (sel_mask),
        .idx_o   (sel_idx),
        .found_o (sel_found),
        .last_o  (sel_last)
    );

    // mask_q holds slices not yet presented; the presented one is cleared on selection.
    always_comb begin
        mask_d = mask_q;
        if (in_xfer || advance) begin
            mask_d = sel_mask & ~(RATIO'(1) << sel_idx);
        end else if (out_xfer) begin
            mask_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    logic [IdxW-1:0] cnt_q;
    logic            unused_slice_valid;

    assign unused_slice_valid = ^i_slice_valid_in;
    assign eff_mask  = '1;
    assign sel_idx   = in_xfer ? '0 : cnt_q + IdxW'(1);
    assign sel_found = 1'b1;
    assign sel_last  = (sel_idx == IdxW'(RATIO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (in_xfer || advance) begin
            cnt_q <= sel_idx;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        out_d   = out_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (in_xfer) begin
            data_d = i_data_in;
            if (sel_found) begin
                state_d = SEND;
                valid_d = 1'b1;
                last_d  = sel_last;
                out_d   = word[sel_idx*WIDTH_OUT +: WIDTH_OUT];
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        end else if (advance) begin
            last_d = sel_last;
            out_d  = word[sel_idx*WIDTH_OUT +: WIDTH_OUT];
        end else if (out_xfer) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign o_data_out  = out_q;
    assign o_valid_out = valid_q;
    assign o_last_out  = last_q;
    assign o_busy      = (state_q == SEND);

`ifndef SYNTHESIS
    int unsigned exp_cnt_q, got_cnt_q;

    // Every word must yield exactly popcount(effective mask) slices, ending on the last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnt_q <= 0;
            got_cnt_q <= 0;
        end else begin
            if (out_xfer && last_q) begin
                assert (got_cnt_q + 1 == exp_cnt_q)
                else $error("tdm_mux: slice count %0d, expected %0d", got_cnt_q + 1, exp_cnt_q);
            end
            if (advance) begin
                got_cnt_q <= got_cnt_q + 1;
            end
            if (in_xfer) begin
                exp_cnt_q <= popcount(64'(eff_mask));
                got_cnt_q <= 0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tdm_mux.sv
// Directed bench for tdm_mux (16-bit word, 4-bit slices); honours TDM_MUX_SKIP_EN if defined.
module tb_tdm_mux;

`ifdef TDM_MUX_SKIP_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  mask_in;
    logic        valid_in;
    logic        ready_out;
    logic [3:0]  data_out;
    logic        valid_out;
    logic        last_out;
    logic        ready_in;
    logic        busy;

    int checks = 0;
    int errors = 0;

    tdm_mux #(.WIDTH_IN(16), .WIDTH_OUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_data_in        (data_in),
        .i_slice_valid_in (mask_in),
        .i_valid_in       (valid_in),
        .o_ready_out      (ready_out),
        .o_data_out       (data_out),
        .o_valid_out      (valid_out),
        .o_last_out       (last_out),
        .i_ready_in       (ready_in),
        .o_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [15:0] d;
        logic [3:0]  m;
        logic        r;
        logic        er;
        logic        ev;
        logic [3:0]  ed;
        logic        el;
        logic        eb;
    } vec_t;

    typedef struct {
        logic [3:0] d;
        logic       l;
    } slice_t;

    vec_t   vecs[$];
    slice_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic v, input logic [15:0] d, input logic [3:0] m,
                       input logic r, input logic er, input logic ev, input logic [3:0] ed,
                       input logic el, input logic eb);
        vec_t t;
        t.name = name; t.v = v; t.d = d; t.m = m; t.r = r;
        t.er = er; t.ev = ev; t.ed = ed; t.el = el; t.eb = eb;
        vecs.push_back(t);
    endtask

    // Expected slice stream for one word under the current build.
    task automatic model_word(input logic [15:0] d, input logic [3:0] m);
        logic [3:0]  eff;
        logic [15:0] w;
        slice_t      s;
        eff = Skip ? m : 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (eff[k]) begin
                w   = d >> (4 * k);
                s.d = w[3:0];
                s.l = ((eff >> (k + 1)) == 4'h0);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] m, input logic r);
        valid_in = v; data_in = d; mask_in = m; ready_in = r;
    endtask

    initial begin
        logic [15:0] words[3];
        logic [3:0]  masks[3];
        int          wi, rx, total, cyc;
        bit          prev_in;

        rst_n = 1'b1;
        drive(1'b0, 16'h0, 4'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("reset valid", valid_out, 1'b0);
        check("reset last", last_out, 1'b0);
        check("reset data", data_out, 4'h0);
        check("reset busy", busy, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("ready after reset", ready_out, 1'b1);

        // 1: full word, no stalls; a valid_in while mid-word must not be accepted.
        add("t1 idle",   0, 16'h0,    4'h0, 1, 1, 0, 4'h0, 0, 0);
        add("t1 accept", 1, 16'hDCBA, 4'hF, 1, 1, 0, 4'h0, 0, 0);
        add("t1 A",      0, 16'h0,    4'h0, 1, 0, 1, 4'hA, 0, 1);
        add("t1 B",      0, 16'h0,    4'h0, 1, 0, 1, 4'hB, 0, 1);
        add("t1 C",      1, 16'h1111, 4'hF, 1, 0, 1, 4'hC, 0, 1);
        add("t1 D",      0, 16'h0,    4'h0, 1, 1, 1, 4'hD, 1, 1);
        add("t1 done",   0, 16'h0,    4'h0, 1, 1, 0, 4'h0, 0, 0);
        // 2: stall on B, then stall on D (ready must stay low while last is stalled).
        add("t2 accept", 1, 16'hDCBA, 4'hF, 1, 1, 0, 4'h0, 0, 0);
        add("t2 A",      0, 16'h0,    4'h0, 1, 0, 1, 4'hA, 0, 1);
        add("t2 B st1",  0, 16'h0,    4'h0, 0, 0, 1, 4'hB, 0, 1);
        add("t2 B st2",  0, 16'h0,    4'h0, 0, 0, 1, 4'hB, 0, 1);
        add("t2 B st3",  0, 16'h0,    4'h0, 0, 0, 1, 4'hB, 0, 1);
        add("t2 B go",   0, 16'h0,    4'h0, 1, 0, 1, 4'hB, 0, 1);
        add("t2 C",      0, 16'h0,    4'h0, 1, 0, 1, 4'hC, 0, 1);
        add("t2 D st",   0, 16'h0,    4'h0, 0, 0, 1, 4'hD, 1, 1);
        add("t2 D go",   0, 16'h0,    4'h0, 1, 1, 1, 4'hD, 1, 1);
        add("t2 done",   0, 16'h0,    4'h0, 1, 1, 0, 4'h0, 0, 0);
        // 3: sparse mask.
        add("t3 accept", 1, 16'h4321, 4'h5, 1, 1, 0, 4'h0, 0, 0);
`ifdef TDM_MUX_SKIP_EN
        add("t3 s0",     0, 16'h0,    4'h0, 1, 0, 1, 4'h1, 0, 1);
        add("t3 s2",     0, 16'h0,    4'h0, 1, 1, 1, 4'h3, 1, 1);
`else
        add("t3 s0",     0, 16'h0,    4'h0, 1, 0, 1, 4'h1, 0, 1);
        add("t3 s1",     0, 16'h0,    4'h0, 1, 0, 1, 4'h2, 0, 1);
        add("t3 s2",     0, 16'h0,    4'h0, 1, 0, 1, 4'h3, 0, 1);
        add("t3 s3",     0, 16'h0,    4'h0, 1, 1, 1, 4'h4, 1, 1);
`endif
        add("t3 done",   0, 16'h0,    4'h0, 1, 1, 0, 4'h0, 0, 0);
        // 4: empty mask.
        add("t4 accept", 1, 16'h8765, 4'h0, 1, 1, 0, 4'h0, 0, 0);
`ifdef TDM_MUX_SKIP_EN
        add("t4 drop1",  0, 16'h0,    4'h0, 1, 1, 0, 4'h0, 0, 0);
        add("t4 drop2",  0, 16'h0,    4'h0, 1, 1, 0, 4'h0, 0, 0);
`else
        add("t4 s0",     0, 16'h0,    4'h0, 1, 0, 1, 4'h5, 0, 1);
        add("t4 s1",     0, 16'h0,    4'h0, 1, 0, 1, 4'h6, 0, 1);
        add("t4 s2",     0, 16'h0,    4'h0, 1, 0, 1, 4'h7, 0, 1);
        add("t4 s3",     0, 16'h0,    4'h0, 1, 1, 1, 4'h8, 1, 1);
        add("t4 done",   0, 16'h0,    4'h0, 1, 1, 0, 4'h0, 0, 0);
`endif
        // Back-to-back load on the last slice of the previous word.
        add("bb accept", 1, 16'hDCBA, 4'hF, 1, 1, 0, 4'h0, 0, 0);
        add("bb A",      0, 16'h0,    4'h0, 1, 0, 1, 4'hA, 0, 1);
        add("bb B",      0, 16'h0,    4'h0, 1, 0, 1, 4'hB, 0, 1);
        add("bb C",      0, 16'h0,    4'h0, 1, 0, 1, 4'hC, 0, 1);
        add("bb D+load", 1, 16'h9876, 4'hF, 1, 1, 1, 4'hD, 1, 1);
        add("bb next",   0, 16'h0,    4'h0, 1, 0, 1, 4'h6, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].d, vecs[i].m, vecs[i].r);
            #1;
            check({vecs[i].name, " ready"}, ready_out, vecs[i].er);
            check({vecs[i].name, " valid"}, valid_out, vecs[i].ev);
            check({vecs[i].name, " last"}, last_out, vecs[i].el);
            check({vecs[i].name, " busy"}, busy, vecs[i].eb);
            if (vecs[i].ev) check({vecs[i].name, " data"}, data_out, vecs[i].ed);
        end

        // 5: async reset mid-word after slice A has been taken.
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        drive(1'b1, 16'hDCBA, 4'hF, 1'b1);
        @(negedge clk) drive(1'b0, 16'h0, 4'h0, 1'b1);
        #1 check("t5 A", data_out, 4'hA);
        @(negedge clk);
        #1 check("t5 B", data_out, 4'hB);
        #2 rst_n = 1'b0;
        #1;
        check("t5 rst valid", valid_out, 1'b0);
        check("t5 rst data", data_out, 4'h0);
        check("t5 rst last", last_out, 1'b0);
        check("t5 rst busy", busy, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("t5 ready", ready_out, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("t5 no residue", valid_out, 1'b0);
        end

        // 6: three back-to-back words under random downstream stalls.
        words = '{16'h3C5A, 16'hF00D, 16'h1234};
        masks = '{4'hB, 4'h6, 4'h9};
        exp_q.delete();
        for (int i = 0; i < 3; i++) model_word(words[i], masks[i]);
        total   = exp_q.size();
        wi      = 0;
        rx      = 0;
        cyc     = 0;
        prev_in = 1'b0;
        while ((wi < 3 || exp_q.size() > 0) && cyc < 300) begin
            @(negedge clk);
            if (wi < 3) drive(1'b1, words[wi], masks[wi], ($urandom_range(0, 3) != 0));
            else drive(1'b0, 16'h0, 4'h0, ($urandom_range(0, 3) != 0));
            #1;
            if (prev_in) check("t6 no bubble", valid_out, 1'b1);
            if (valid_out && last_out && ready_in) check("t6 ready on last", ready_out, 1'b1);
            if (valid_out && ready_in) begin
                rx++;
                if (exp_q.size() > 0) begin
                    check("t6 slice data", data_out, exp_q[0].d);
                    check("t6 slice last", last_out, exp_q[0].l);
                    void'(exp_q.pop_front());
                end
            end
            prev_in = valid_in && ready_out;
            if (prev_in) wi++;
            cyc++;
        end
        check("t6 words accepted", wi, 3);
        check("t6 slice count", rx, total);
        @(negedge clk) drive(1'b0, 16'h0, 4'h0, 1'b1);
        #1 check("t6 idle after", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
